// File: rtl/inst_buffer.sv
// Circular instruction buffer between fetch and decode, WIDTH slots per side.
// Optional same-cycle empty bypass is compiled in when INST_BUFFER_BYPASS_EN is defined.
module inst_buffer #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               in_valid,
    input  logic [WIDTH-1:0][31:0]         in_inst,
    input  logic [WIDTH-1:0][31:0]         in_pc,
    output logic [WIDTH-1:0]               in_avail,
    output logic [WIDTH-1:0]               out_valid,
    output logic [WIDTH-1:0][31:0]         out_inst,
    output logic [WIDTH-1:0][31:0]         out_pc,
    input  logic [WIDTH-1:0]               out_ready,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(WIDTH + 1);

    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [31:0]      r_mem_inst [DEPTH];
    logic [31:0]      r_mem_pc   [DEPTH];

    logic [CW-1:0]    w_free;
    logic [WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_deq_vec;
    logic [SW-1:0]    w_enq;
    logic [SW-1:0]    w_deq;
    logic [SW-1:0]    w_skip;
    logic             w_byp;
    logic             w_run_in;
    logic             w_run_out;
    logic [AW-1:0]    w_rd_addr;
    logic [WIDTH-1:0] w_wr_en;
    logic [AW-1:0]    w_wr_addr [WIDTH];

    assign count = r_count;

    // Accept side: free-space credit from registered count, contiguous accepted prefix
    always_comb begin
        w_free   = CW'(DEPTH) - r_count;
        w_run_in = 1'b1;
        w_enq    = {SW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            in_avail[i] = (w_free > CW'(i)) && !flush;
            w_run_in    = w_run_in && in_valid[i] && in_avail[i];
            w_acc[i]    = w_run_in;
            w_enq       = w_enq + SW'(w_run_in);
        end
    end

    // Decode side: present oldest entries (or bypassed input when empty), contiguous dequeue prefix
    always_comb begin
        w_byp = 1'b0;
`ifdef INST_BUFFER_BYPASS_EN
        w_byp = (r_count == {CW{1'b0}}) && !flush;
`endif
        w_run_out = 1'b1;
        w_deq     = {SW{1'b0}};
        w_rd_addr = {AW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            w_rd_addr = r_head + AW'(i);
            if (w_byp) begin
                out_valid[i] = w_acc[i];
                out_inst[i]  = in_inst[i];
                out_pc[i]    = in_pc[i];
            end else begin
                out_valid[i] = (r_count > CW'(i)) && !flush;
                out_inst[i]  = r_mem_inst[w_rd_addr];
                out_pc[i]    = r_mem_pc[w_rd_addr];
            end
            w_run_out    = w_run_out && out_valid[i] && out_ready[i];
            w_deq_vec[i] = w_run_out;
            w_deq        = w_deq + SW'(w_run_out);
        end
        w_skip = w_byp ? w_deq : {SW{1'b0}};
    end

    // Write enables: bypassed-and-consumed slots are skipped, the rest pack from tail
    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            w_wr_en[k]   = w_acc[k] && (SW'(k) >= w_skip) && !flush;
            w_wr_addr[k] = r_tail + AW'(k) - AW'(w_skip);
        end
    end

    // Pointer and occupancy state; reset outranks flush, flush outranks traffic
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= {AW{1'b0}};
            r_tail  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else if (flush) begin
            r_head  <= {AW{1'b0}};
            r_tail  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            r_head  <= r_head + AW'(w_deq - w_skip);
            r_tail  <= r_tail + AW'(w_enq - w_skip);
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end

    // Entry storage; contents are don't-care after reset so no reset here
    always_ff @(posedge clock) begin
        for (int k = 0; k < WIDTH; k++) begin
            if (w_wr_en[k]) begin
                r_mem_inst[w_wr_addr[k]] <= in_inst[k];
                r_mem_pc[w_wr_addr[k]]   <= in_pc[k];
            end
        end
    end
endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer (WIDTH=2, DEPTH=8).
// Bypass scenario runs only when INST_BUFFER_BYPASS_EN is defined.
module tb_inst_buffer;
    logic             clock = 1'b0;
    logic             reset;
    logic             flush;
    logic [1:0]       in_valid;
    logic [1:0][31:0] in_inst;
    logic [1:0][31:0] in_pc;
    logic [1:0]       in_avail;
    logic [1:0]       out_valid;
    logic [1:0][31:0] out_inst;
    logic [1:0][31:0] out_pc;
    logic [1:0]       out_ready;
    logic [3:0]       count;

    int checks   = 0;
    int failures = 0;

    inst_buffer #(.WIDTH(2), .DEPTH(8)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_avail(in_avail),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_ready(out_ready), .count(count)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic [1:0] rdy);
        in_valid   = v;
        in_pc[0]   = pc0;
        in_pc[1]   = pc1;
        in_inst[0] = pc0 ^ 32'hA5A5_0000;
        in_inst[1] = pc1 ^ 32'hA5A5_0000;
        out_ready  = rdy;
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        flush = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        step;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL reset_out_valid got=%b exp=00", out_valid); end
        checks++; if (in_avail !== 2'b11) begin failures++; $display("FAIL reset_in_avail got=%b exp=11", in_avail); end
    endtask

    task automatic test_fill;
        logic [1:0] exp_avail;
        logic [3:0] exp_cnt;
        do_reset;
        for (int c = 0; c < 5; c++) begin
            drive(2'b11, 32'(8 * c), 32'(8 * c + 4), 2'b00);
            exp_avail = (c < 4) ? 2'b11 : 2'b00;
            checks++; if (in_avail !== exp_avail) begin failures++; $display("FAIL fill_avail c=%0d got=%b exp=%b", c, in_avail, exp_avail); end
            step;
            exp_cnt = (c < 4) ? 4'(2 * (c + 1)) : 4'd8;
            checks++; if (count !== exp_cnt) begin failures++; $display("FAIL fill_count c=%0d got=%0d exp=%0d", c, count, exp_cnt); end
        end
        for (int d = 0; d < 4; d++) begin
            drive(2'b00, 32'h0, 32'h0, 2'b11);
            checks++; if (out_valid !== 2'b11) begin failures++; $display("FAIL drain_valid d=%0d got=%b exp=11", d, out_valid); end
            checks++; if (out_pc[0] !== 32'(8 * d) || out_pc[1] !== 32'(8 * d + 4)) begin
                failures++; $display("FAIL drain_pc d=%0d got=%h,%h exp=%h,%h", d, out_pc[0], out_pc[1], 8 * d, 8 * d + 4); end
            step;
        end
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        checks++; if (count !== 4'd0 || out_valid !== 2'b00) begin
            failures++; $display("FAIL fill_fifth_dropped count=%0d valid=%b exp=0,00", count, out_valid); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_pc;
        exp_pc = 32'h0;
        do_reset;
        for (int c = 0; c < 14; c++) begin
            drive(2'b11, 32'(8 * c), 32'(8 * c + 4), 2'b11);
            if (c > 0) begin
                checks++; if (out_valid !== 2'b11) begin failures++; $display("FAIL wrap_valid c=%0d got=%b exp=11", c, out_valid); end
                checks++; if (out_pc[0] !== exp_pc || out_pc[1] !== exp_pc + 32'd4) begin
                    failures++; $display("FAIL wrap_pc c=%0d got=%h,%h exp=%h,%h", c, out_pc[0], out_pc[1], exp_pc, exp_pc + 32'd4); end
                checks++; if (out_inst[1] !== ((exp_pc + 32'd4) ^ 32'hA5A5_0000)) begin
                    failures++; $display("FAIL wrap_inst c=%0d got=%h exp=%h", c, out_inst[1], (exp_pc + 32'd4) ^ 32'hA5A5_0000); end
                exp_pc = exp_pc + 32'd8;
            end
            step;
            checks++; if (count !== 4'd2) begin failures++; $display("FAIL wrap_count c=%0d got=%0d exp=2", c, count); end
        end
    endtask

    task automatic test_partial;
        do_reset;
        drive(2'b11, 32'h100, 32'h104, 2'b00);
        step;
        drive(2'b01, 32'h108, 32'h10C, 2'b00);
        step;
        drive(2'b00, 32'h0, 32'h0, 2'b01);
        checks++; if (count !== 4'd3) begin failures++; $display("FAIL partial_setup got=%0d exp=3", count); end
        checks++; if (out_pc[0] !== 32'h100) begin failures++; $display("FAIL partial_head0 got=%h exp=100", out_pc[0]); end
        step;
        drive(2'b00, 32'h0, 32'h0, 2'b10);
        checks++; if (count !== 4'd2) begin failures++; $display("FAIL partial_deq1 got=%0d exp=2", count); end
        checks++; if (out_pc[0] !== 32'h104) begin failures++; $display("FAIL partial_head1 got=%h exp=104", out_pc[0]); end
        step;
        drive(2'b10, 32'h200, 32'h204, 2'b00);
        checks++; if (count !== 4'd2 || out_pc[0] !== 32'h104) begin
            failures++; $display("FAIL partial_gap_ready count=%0d pc=%h exp=2,104", count, out_pc[0]); end
        step;
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        checks++; if (count !== 4'd2) begin failures++; $display("FAIL partial_gap_valid got=%0d exp=2", count); end
    endtask

    task automatic test_flush;
        do_reset;
        for (int c = 0; c < 3; c++) begin
            drive(2'b11, 32'(16 * c), 32'(16 * c + 4), 2'b00);
            step;
        end
        flush = 1'b1;
        drive(2'b11, 32'h300, 32'h304, 2'b11);
        checks++; if (out_valid !== 2'b00 || in_avail !== 2'b00) begin
            failures++; $display("FAIL flush_comb valid=%b avail=%b exp=00,00", out_valid, in_avail); end
        step;
        flush = 1'b0;
        drive(2'b11, 32'h400, 32'h404, 2'b00);
        checks++; if (count !== 4'd0 || out_valid !== 2'b00) begin
            failures++; $display("FAIL flush_after count=%0d valid=%b exp=0,00", count, out_valid); end
        step;
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        checks++; if (count !== 4'd2 || out_pc[0] !== 32'h400 || out_pc[1] !== 32'h404) begin
            failures++; $display("FAIL flush_refill count=%0d pc=%h,%h exp=2,400,404", count, out_pc[0], out_pc[1]); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        drive(2'b11, 32'h500, 32'h504, 2'b00); step;
        drive(2'b11, 32'h508, 32'h50C, 2'b00); step;
        drive(2'b01, 32'h510, 32'h514, 2'b00); step;
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        checks++; if (count !== 4'd5) begin failures++; $display("FAIL midreset_setup got=%0d exp=5", count); end
        reset = 1'b1;
        drive(2'b11, 32'h600, 32'h604, 2'b11);
        step;
        reset = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        checks++; if (count !== 4'd0 || out_valid !== 2'b00 || in_avail !== 2'b11) begin
            failures++; $display("FAIL midreset count=%0d valid=%b avail=%b exp=0,00,11", count, out_valid, in_avail); end
    endtask

`ifdef INST_BUFFER_BYPASS_EN
    task automatic test_bypass;
        do_reset;
        drive(2'b11, 32'h40, 32'h44, 2'b01);
        checks++; if (out_valid[0] !== 1'b1 || out_pc[0] !== 32'h40) begin
            failures++; $display("FAIL bypass_same valid=%b pc=%h exp=1,40", out_valid[0], out_pc[0]); end
        step;
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        checks++; if (count !== 4'd1 || out_pc[0] !== 32'h44) begin
            failures++; $display("FAIL bypass_next count=%0d pc=%h exp=1,44", count, out_pc[0]); end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 2'b00;
        in_inst   = '{default: 32'h0};
        in_pc     = '{default: 32'h0};
        out_ready = 2'b00;
        test_reset;
        test_fill;
        test_wrap;
        test_partial;
        test_flush;
        test_reset_mid;
`ifdef INST_BUFFER_BYPASS_EN
        test_bypass;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 2: instruction slots per cycle on each side.
REQ-002 SHALL have parameter DEPTH, default 8: entries; a power of 2 and >= 2*WIDTH.
REQ-003 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1: discards all buffered entries (branch resolved wrong).
REQ-006 SHALL have port in_valid, input, WIDTH: fetch slot i carries an instruction.
REQ-007 SHALL have port in_inst, input, WIDTH x 32: fetched instruction words.
REQ-008 SHALL have port in_pc, input, WIDTH x 32: PC of each fetched word.
REQ-009 SHALL have port in_avail, output, WIDTH: slot i will be accepted if valid; the upstream PC generator advances by popcount(in_avail).
REQ-010 SHALL have port out_valid, output, WIDTH: decode slot i holds an instruction.
REQ-011 SHALL have port out_inst, output, WIDTH x 32: instruction to decode slot i.
REQ-012 SHALL have port out_pc, output, WIDTH x 32: PC to decode slot i.
REQ-013 SHALL have port out_ready, input, WIDTH: decode consumes slot i this cycle.
REQ-014 SHALL have port count, output, clog2(DEPTH+1): occupied entries.

Function
REQ-015 SHALL store entries in a circular array with head (oldest) and tail pointers, each wrapping modulo DEPTH.
REQ-016 SHALL drive in_avail[i] = 1 iff (DEPTH - count) > i and flush = 0; computed from registered count only, with no credit for same-cycle dequeue.
REQ-017 SHALL accept the contiguous prefix of slots with in_valid[i] && in_avail[i]; slots after the first unaccepted slot are dropped.
REQ-018 SHALL write accepted slot k to entry (tail + k) mod DEPTH, preserving slot order.
REQ-019 SHALL drive out_valid[i] = 1 iff count > i and flush = 0, with out_inst[i]/out_pc[i] from entry (head + i) mod DEPTH.
REQ-020 SHALL dequeue the contiguous prefix of slots with out_valid[i] && out_ready[i]; ready on a slot after a gap is ignored.
REQ-021 SHALL update count_next = count + enq - deq, and advance head by deq and tail by enq, on the same edge; simultaneous enqueue and dequeue when full or empty SHALL be legal.
REQ-022 SHALL make an enqueued entry visible on out_* one cycle after acceptance (1-cycle latency, no bypass), except as REQ-029 provides.
REQ-023 SHALL, on flush, set head = tail = 0 and count = 0 on the next edge, discarding same-cycle enqueue and dequeue; flush has priority over all other inputs.
REQ-024 SHALL keep out_inst and out_pc stable for valid slots not dequeued.

Reset
REQ-025 SHALL, on reset, set head = 0, tail = 0, count = 0; reset has priority over flush.
REQ-026 SHALL output, during and after reset: out_valid = 0, in_avail = all ones (flush low), count = 0; stored array contents are don't-care.
REQ-027 SHALL treat reset asserted mid-operation identically to reset from power-up; no entry survives.

Configuration
REQ-028 SHALL compile the empty-bypass path only when macro INST_BUFFER_BYPASS_EN is defined.
REQ-029 With INST_BUFFER_BYPASS_EN defined, SHALL, when count = 0 and flush = 0, drive out_* from the accepted in_* prefix in the same cycle; bypassed slots dequeued that cycle are not written, and the rest are written starting at tail.
REQ-030 Without INST_BUFFER_BYPASS_EN, SHALL keep out_valid = 0 whenever count = 0, giving strict 1-cycle latency.

Verification (WIDTH=2, DEPTH=8, bypass off unless stated)
REQ-031 SHALL check fill: in_valid=11 every cycle, out_ready=00 -> count 2,4,6,8; in_avail=00 at count 8; the 5th pair is not accepted.
REQ-032 SHALL check wrap and order: steady in_valid=11 with PCs 0,4,8,..., out_ready=11 -> out_pc sequence 0,4,8,... is gap-free across 3 head wraps, and count stays 2.
REQ-033 SHALL check partial handshake: count=3 (PCs 0x100,0x104,0x108), out_ready=10 -> only 0x100 is dequeued; next out_pc[0]=0x104; out_ready=01 dequeues nothing.
REQ-034 SHALL check flush: count=6 with in_valid=11 and out_ready=11 and flush=1 -> next cycle count=0, out_valid=00, and neither the new pair nor the dequeue takes effect.
REQ-035 SHALL check reset mid-stream: count=5, reset for 1 cycle -> count=0, out_valid=00, in_avail=11.
REQ-036 SHALL check bypass: with INST_BUFFER_BYPASS_EN, empty buffer, in_valid=11 (PCs 0x40,0x44), out_ready=10 -> same-cycle out_pc[0]=0x40 is consumed; next cycle count=1 and out_pc[0]=0x44.
